// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared constants, grant encoding and helpers for the register-bank write-back arbiter.
// Holds the bank geometry defaults and the requester index map used across the slice.
package regbank_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned NREGS_DEF  = 16;

  // Requester slots in the request/grant vectors
  localparam int unsigned REQ_MEM = 0;
  localparam int unsigned REQ_ALU = 1;
  localparam int unsigned NREQ    = 2;

  localparam int unsigned STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  typedef enum logic [1:0] {
    GntNone,
    GntMem,
    GntAlu
  } gnt_e;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/regbank_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: tracks reserved destinations, flags RAW hazards and
// latches a sticky error on reservation/commit protocol violations.
module regbank_wb_arbiter_scoreboard
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              byp_valid,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              sb_err
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             err_q, err_d;
  logic             alloc_conflict;
  logic             clr_unowned;

  // A same-edge commit frees the slot, so re-reserving it then is legal
  assign alloc_conflict = alloc_valid & pending_q[alloc_addr]
                        & ~(clr_valid & (clr_addr == alloc_addr));
  assign clr_unowned    = clr_valid & ~pending_q[clr_addr];

  always_comb begin
    pending_d = pending_q;
    if (clr_valid) begin
      pending_d[clr_addr] = 1'b0;
    end
    // Set after clear: the new reservation wins on a same-register collision
    if (alloc_valid) begin
      pending_d[alloc_addr] = 1'b1;
    end
    err_d = err_q | alloc_conflict | clr_unowned;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Bypass term covers the cycle the bank is being written but still reads stale
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    if (!RST) begin
      hazard_a = pending_q[rd_addr_a] | (byp_valid & (byp_addr == rd_addr_a));
      hazard_b = pending_q[rd_addr_b] | (byp_valid & (byp_addr == rd_addr_b));
    end
  end

  assign sb_err = err_q;

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the 16x16 register bank: MEM/ALU share one write port,
// with ALU anti-starvation, a registered write stage and a RAW scoreboard.
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned NREGS        = NREGS_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              bank_wen,
  output logic [ADDR_W-1:0] bank_waddr,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              sb_err
);

  localparam logic [STARVE_W-1:0] StarveLim = STARVE_W'(STARVE_LIMIT);

  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  gnt_e                gnt_sel;
  logic                force_alu;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_data;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                wen_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;

  assign req[REQ_MEM] = mem_valid;
  assign req[REQ_ALU] = alu_valid;

  assign force_alu = (starve_q >= StarveLim) & req[REQ_ALU];

  // MEM has priority unless the ALU has waited long enough
  always_comb begin
    gnt_sel = GntNone;
    if (!RST) begin
      if (req[REQ_MEM] && !force_alu) begin
        gnt_sel = GntMem;
      end else if (req[REQ_ALU]) begin
        gnt_sel = GntAlu;
      end
    end
  end

  always_comb begin
    gnt      = '0;
    gnt_addr = mem_addr;
    gnt_data = mem_data;
    unique case (gnt_sel)
      GntMem: begin
        gnt[REQ_MEM] = 1'b1;
      end
      GntAlu: begin
        gnt[REQ_ALU] = 1'b1;
        gnt_addr     = alu_addr;
        gnt_data     = alu_data;
      end
      default: ;
    endcase
  end

  assign mem_ready = gnt[REQ_MEM];
  assign alu_ready = gnt[REQ_ALU];

  always_comb begin
    starve_d = '0;
    if (req[REQ_ALU] && !gnt[REQ_ALU]) begin
      starve_d = sat_inc(starve_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Address/data hold their last value when no write is issued
  always_ff @(posedge CLK) begin
    if (RST) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= |gnt;
      if (|gnt) begin
        waddr_q <= gnt_addr;
        wdata_q <= gnt_data;
      end
    end
  end

  assign bank_wen   = wen_q;
  assign bank_waddr = waddr_q;
  assign bank_wdata = wdata_q;

  regbank_wb_arbiter_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .CLK         (CLK),
    .RST         (RST),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .clr_valid   (|gnt),
    .clr_addr    (gnt_addr),
    .byp_valid   (wen_q),
    .byp_addr    (waddr_q),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench for regbank_wb_arbiter: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of the arbitration rules.
module tb_regbank_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic        mem_valid, mem_ready, alu_valid, alu_ready, alloc_valid;
  logic [3:0]  mem_addr, alu_addr, alloc_addr, rd_addr_a, rd_addr_b, bank_waddr;
  logic [15:0] mem_data, alu_data, bank_wdata;
  logic        hazard_a, hazard_b, bank_wen, sb_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          mp[16];
  int          mstarve;
  bit          merr, mwen;
  logic [3:0]  mwaddr;
  logic [15:0] mwdata;

  regbank_wb_arbiter #(
    .DATA_W       (16),
    .ADDR_W       (4),
    .NREGS        (16),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .bank_wen    (bank_wen),
    .bank_waddr  (bank_waddr),
    .bank_wdata  (bank_wdata),
    .sb_err      (sb_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    mem_valid   = 1'b0;
    alu_valid   = 1'b0;
    alloc_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mp[i] = 1'b0;
    mstarve = 0;
    merr    = 1'b0;
    mwen    = 1'b0;
    mwaddr  = '0;
    mwdata  = '0;
  endtask

  function automatic logic [3:0] pick_pending();
    logic [3:0] cand[$];
    for (int i = 0; i < 16; i++) if (mp[i]) cand.push_back(4'(i));
    if (cand.size() == 0) return 4'($urandom_range(0, 15));
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 16'h1234;
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 16'h5678;
    alloc_valid = 1'b1; alloc_addr = 4'd3;
    rd_addr_a = 4'd3; rd_addr_b = 4'd4;
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%b exp=0", mem_ready); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%b exp=0", alu_ready); end
    step();
    step();
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL rst_hazard_a got=%b exp=0", hazard_a); end
    total++; if (bank_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", bank_wen); end
    total++; if (bank_waddr !== 4'd0) begin bad++; $display("FAIL rst_waddr got=%h exp=0", bank_waddr); end
    total++; if (bank_wdata !== 16'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bank_wdata); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL rst_sb_err got=%b exp=0", sb_err); end
    idle();
    RST = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      #1;
      total++;
      if (hazard_a !== 1'b0) begin bad++; $display("FAIL rst_pending r%0d got=%b exp=0", i, hazard_a); end
    end
    step();
  endtask

  task automatic test_single_write();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 4'd3;
    step();
    alloc_valid = 1'b0;
    rd_addr_a = 4'd3; rd_addr_b = 4'd4;
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 16'hBEEF;
    #1;
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL t1_haz_pend got=%b exp=1", hazard_a); end
    total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL t1_haz_b got=%b exp=0", hazard_b); end
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL t1_mem_ready got=%b exp=1", mem_ready); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL t1_alu_ready got=%b exp=0", alu_ready); end
    step();
    mem_valid = 1'b0;
    total++; if (bank_wen !== 1'b1) begin bad++; $display("FAIL t1_wen got=%b exp=1", bank_wen); end
    total++; if (bank_waddr !== 4'd3) begin bad++; $display("FAIL t1_waddr got=%h exp=3", bank_waddr); end
    total++; if (bank_wdata !== 16'hBEEF) begin bad++; $display("FAIL t1_wdata got=%h exp=BEEF", bank_wdata); end
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL t1_haz_byp got=%b exp=1", hazard_a); end
    step();
    total++; if (bank_wen !== 1'b0) begin bad++; $display("FAIL t1_wen_off got=%b exp=0", bank_wen); end
    total++; if (bank_waddr !== 4'd3) begin bad++; $display("FAIL t1_waddr_hold got=%h exp=3", bank_waddr); end
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL t1_haz_clr got=%b exp=0", hazard_a); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL t1_sb_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 4'd1;
    step();
    alloc_addr = 4'd2;
    step();
    alloc_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL t2_mem_first got=%b exp=1", mem_ready); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL t2_alu_wait got=%b exp=0", alu_ready); end
    step();
    mem_valid = 1'b0;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL t2_alu_next got=%b exp=1", alu_ready); end
    total++; if (bank_wen !== 1'b1 || bank_waddr !== 4'd1 || bank_wdata !== 16'h1111) begin
      bad++; $display("FAIL t2_write1 got=%b/%h/%h exp=1/1/1111", bank_wen, bank_waddr, bank_wdata);
    end
    step();
    alu_valid = 1'b0;
    total++; if (bank_wen !== 1'b1 || bank_waddr !== 4'd2 || bank_wdata !== 16'h2222) begin
      bad++; $display("FAIL t2_write2 got=%b/%h/%h exp=1/2/2222", bank_wen, bank_waddr, bank_wdata);
    end
    step();
    total++; if (bank_wen !== 1'b0) begin bad++; $display("FAIL t2_wen_off got=%b exp=0", bank_wen); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL t2_sb_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_starvation();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 4'd8;
    step();
    alloc_addr = 4'd9;
    step();
    alloc_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 4'd8; mem_data = 16'h8001;
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 16'h9999;
    for (int i = 1; i <= 7; i++) begin
      // MEM keeps re-reserving r8 on the edge its own write commits
      alloc_valid = (i != 5);
      alloc_addr  = 4'd8;
      #1;
      total++;
      if (mem_ready !== (i != 5) || alu_ready !== (i == 5)) begin
        bad++;
        $display("FAIL t3_cycle%0d got mem=%b alu=%b exp mem=%b alu=%b",
                 i, mem_ready, alu_ready, (i != 5), (i == 5));
      end
      step();
      if (i == 5) begin
        alu_valid = 1'b0;
        total++;
        if (bank_waddr !== 4'd9 || bank_wdata !== 16'h9999) begin
          bad++; $display("FAIL t3_alu_write got=%h/%h exp=9/9999", bank_waddr, bank_wdata);
        end
      end else begin
        mem_data = 16'h8001 + 16'(i);
      end
    end
    idle();
    step();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL t3_sb_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_same_edge();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 4'd5;
    step();
    mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'h5555;
    step();
    idle();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL t4_same_edge_err got=%b exp=0", sb_err); end
    step();
    rd_addr_a = 4'd5;
    #1;
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL t4_pend5 got=%b exp=1", hazard_a); end
    alloc_valid = 1'b1; alloc_addr = 4'd5;
    step();
    alloc_valid = 1'b0;
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL t4_double_alloc got=%b exp=1", sb_err); end
  endtask

  task automatic test_bad_grant();
    do_reset();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL t5_err_clean got=%b exp=0", sb_err); end
    mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 16'h7777;
    step();
    mem_valid = 1'b0;
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL t5_err_set got=%b exp=1", sb_err); end
    alloc_valid = 1'b1; alloc_addr = 4'd2;
    step();
    alloc_valid = 1'b0;
    step();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL t5_err_sticky got=%b exp=1", sb_err); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    rd_addr_a = 4'd2;
    #1;
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL t5_err_rst got=%b exp=0", sb_err); end
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL t5_pend_rst got=%b exp=0", hazard_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Reset at the grant edge: the request is never accepted
    mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 16'h6666;
    RST = 1'b1;
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL t6_ready_in_rst got=%b exp=0", mem_ready); end
    step();
    total++; if (bank_wen !== 1'b0) begin bad++; $display("FAIL t6a_wen got=%b exp=0", bank_wen); end
    idle();
    RST = 1'b0;
    step();
    alloc_valid = 1'b1; alloc_addr = 4'd4;
    step();
    alloc_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 16'h4444;
    step();
    mem_valid = 1'b0;
    RST = 1'b1;
    rd_addr_a = 4'd4; rd_addr_b = 4'd4;
    #1;
    total++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
      bad++; $display("FAIL t6_haz_in_rst got=%b%b exp=00", hazard_a, hazard_b);
    end
    step();
    total++; if (bank_wen !== 1'b0 || bank_waddr !== 4'd0 || bank_wdata !== 16'd0) begin
      bad++; $display("FAIL t6b_dropped got=%b/%h/%h exp=0/0/0000", bank_wen, bank_waddr, bank_wdata);
    end
    RST = 1'b0;
    #1;
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL t6_pend_clr got=%b exp=0", hazard_a); end
  endtask

  task automatic test_random();
    bit          emr, ear, eha, ehb, g;
    logic [3:0]  ga;
    logic [15:0] gd;
    do_reset();
    model_reset();
    for (int c = 0; c < 240; c++) begin
      if (c % 60 == 59) begin
        do_reset();
        model_reset();
      end
      if (!mem_valid && $urandom_range(0, 2) != 0) begin
        mem_valid = 1'b1; mem_addr = pick_pending(); mem_data = 16'($urandom);
      end
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1'b1; alu_addr = pick_pending(); alu_data = 16'($urandom);
      end
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_addr  = 4'($urandom_range(0, 15));
      rd_addr_a   = ($urandom_range(0, 1) == 0) ? mwaddr : 4'($urandom_range(0, 15));
      rd_addr_b   = 4'($urandom_range(0, 15));
      #1;
      emr = mem_valid && !(mstarve >= 4 && alu_valid);
      ear = alu_valid && !emr;
      eha = mp[rd_addr_a] || (mwen && mwaddr == rd_addr_a);
      ehb = mp[rd_addr_b] || (mwen && mwaddr == rd_addr_b);
      total++; if (mem_ready !== emr) begin bad++; $display("FAIL rnd%0d_mem_ready got=%b exp=%b", c, mem_ready, emr); end
      total++; if (alu_ready !== ear) begin bad++; $display("FAIL rnd%0d_alu_ready got=%b exp=%b", c, alu_ready, ear); end
      total++; if (hazard_a !== eha) begin bad++; $display("FAIL rnd%0d_hazard_a got=%b exp=%b", c, hazard_a, eha); end
      total++; if (hazard_b !== ehb) begin bad++; $display("FAIL rnd%0d_hazard_b got=%b exp=%b", c, hazard_b, ehb); end
      g  = emr || ear;
      ga = emr ? mem_addr : alu_addr;
      gd = emr ? mem_data : alu_data;
      if (alloc_valid && mp[alloc_addr] && !(g && ga == alloc_addr)) merr = 1'b1;
      if (g && !mp[ga]) merr = 1'b1;
      if (g) mp[ga] = 1'b0;
      if (alloc_valid) mp[alloc_addr] = 1'b1;
      if (alu_valid && !ear) mstarve = (mstarve >= 15) ? 15 : mstarve + 1;
      else mstarve = 0;
      mwen = g;
      if (g) begin
        mwaddr = ga;
        mwdata = gd;
      end
      step();
      total++; if (bank_wen !== mwen) begin bad++; $display("FAIL rnd%0d_wen got=%b exp=%b", c, bank_wen, mwen); end
      total++; if (bank_waddr !== mwaddr || bank_wdata !== mwdata) begin
        bad++; $display("FAIL rnd%0d_wbus got=%h/%h exp=%h/%h", c, bank_waddr, bank_wdata, mwaddr, mwdata);
      end
      total++; if (sb_err !== merr) begin bad++; $display("FAIL rnd%0d_sb_err got=%b exp=%b", c, sb_err, merr); end
      if (emr) mem_valid = 1'b0;
      if (ear) alu_valid = 1'b0;
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    idle();
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0;
    alloc_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_starvation();
    test_same_edge();
    test_bad_grant();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
